pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
Next-generation main controller for the pipelined CPU. It decodes the 5-bit opcodeFunc in the ID stage into datapath controls and sequences IDLE/STARTING/RUN.
- Adds load-use hazard stalling, parametrised branch-flush bubbles and a hardware return-stack occupancy counter with overflow/underflow protection.
- Sits between the IF/ID register and the ID/EX register; datapath uses stall/flush to hold PC and insert bubbles.

Parameters:
PC_W, 12, program counter width (pc input).
REG_ADDR_W, 3, register-file address width.
FLUSH_DEPTH, 2, bubble cycles inserted after any taken control transfer (1..7).
STACK_DEPTH, 8, return-stack capacity tracked by the occupancy counter (1..255).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
start  in  1  start request
halt  in  1  halt request from datapath
pc  in  PC_W  current PC (informational; not used in decode)
opcodeFunc  in  5  ID-stage opcode/function
Cin, Zin  in  1 each  carry/zero flags
idRs1, idRs2  in  REG_ADDR_W  ID-stage source registers
exRd  in  REG_ADDR_W  destination of instruction in EX
exLdm  in  1  instruction in EX is a load
push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, cWriteEn, zWriteEn  out  1 each  datapath controls
aluOp  out  4  ALU operation
pcSel  out  2  0 = PC+1, 1 = jump target, 2 = stack top, 3 = branch target
stall  out  1  hold PC and IF/ID, bubble into ID/EX
flush  out  1  squash IF/ID contents
busy  out  1  state != IDLE
spCount  out  8  return-stack occupancy
stackErr  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, flush counter=0, spCount=0, stackErr=0.
- All control outputs are combinational from state and inputs, and are 0 outside RUN. Hence all are 0 in the cycle after reset.
- States and transitions:
  - IDLE -> STARTING when start=1.
  - STARTING -> STARTING while start=1, else RUN.
  - RUN -> IDLE when halt=1; halt has priority over everything, and no controls are asserted in that cycle.
  - RUN -> FLUSH on a taken transfer. Counter loads FLUSH_DEPTH-1.
  - FLUSH: outputs 0, flush=1; counter decrements. Exit to RUN when the counter is 0, or to IDLE on halt.
  - start is ignored outside IDLE/STARTING.
- Decode in RUN; unlisted codes are NOPs.
  - 00xxx: regWriteEn, cWriteEn, zWriteEn=1; aluOp={1'b0,opf[2:0]}.
  - 01xxx: same as 00xxx plus immAndmem=1.
  - 11000/11001: regWriteEn, cWriteEn, zWriteEn=1; aluOp=10xx.
  - 11010/11011: regWriteEn, zWriteEn=1; aluOp=10xx; no cWriteEn.
  - 10000 LDM: regWriteEn, immAndmem, ldm=1; aluOp=0.
  - 10001 STM: memWriteEn, immAndmem, stm=1; aluOp=0.
  - 10100/10101/10110/10111: pcSel=3 iff Z / !Z / C / !C respectively.
  - 11100 JMP: pcSel=1.
  - 11101 CALL: pcSel=1, push=1.
  - 11110 RET: pcSel=2, pop=1.
- Source usage:
  - rs1 is read by 00xxx, 01xxx, 110xx, LDM and STM.
  - rs2 is read by 00xxx, 110xx and STM.
- Load-use hazard: in RUN, when exLdm=1 and exRd equals a used source, stall=1 and all other outputs are 0. State stays RUN and the condition is re-evaluated next cycle.
- Taken transfer: branch taken, JMP, CALL or RET, including stack-protected cases below. Controls are asserted for one cycle, then the FLUSH state follows.
- Stack counter:
  - CALL with spCount < STACK_DEPTH: spCount+1.
  - CALL with spCount == STACK_DEPTH: push=0, pcSel=0 (NOP, no flush); stackErr set.
  - RET with spCount > 0: spCount-1.
  - RET with spCount == 0: pop=0, pcSel=0 (NOP, no flush); stackErr set.
  - stackErr clears only on reset. spCount is unchanged by halt and cleared only by reset.
- Reset mid-FLUSH or mid-stall returns to IDLE immediately, with the counter cleared.
- Latency: decode is combinational, 0 cycles. A taken transfer costs 1 + FLUSH_DEPTH cycles; a load-use hazard costs 1 stall cycle per blocking EX load.

Test Plan:
- Reset then start=1 for 2 cycles then 0 -> STARTING, STARTING, RUN. opcodeFunc=00011 gives aluOp=0011, regWriteEn=cWriteEn=zWriteEn=1; all outputs 0 before RUN.
- RUN, exLdm=1, exRd=3, opcodeFunc=00000, idRs2=3 -> stall=1, regWriteEn=0 for 1 cycle. exLdm=0 next cycle -> normal decode. opcodeFunc=01000 with idRs2=3 -> no stall.
- RUN, opcodeFunc=10100, Zin=1, FLUSH_DEPTH=2 -> pcSel=3, then 2 cycles flush=1 with all controls 0, then RUN. With Zin=0: pcSel=0, no flush.
- STACK_DEPTH=2: CALL, CALL, CALL -> spCount 1, 2, 2. Third CALL has push=0, pcSel=0, stackErr=1. RET x3 -> spCount 1, 0, 0; third RET has pop=0.
- Halt during FLUSH, and halt together with a taken BZ -> next state IDLE, busy=0, no pcSel asserted in the halt cycle.
- rst=0 during FLUSH with spCount=3 and stackErr=1 -> next cycle IDLE, spCount=0, stackErr=0, flush=0.

Source files
------------

// File: rtl/pipe_controller.sv
// Main pipeline controller: ID-stage decode, IDLE/STARTING/RUN/FLUSH sequencing,
// load-use stalling, post-transfer flush bubbles and return-stack occupancy tracking.
module pipe_controller #(
  parameter int PC_W        = 12,
  parameter int REG_ADDR_W  = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [PC_W-1:0]       pc,
  input  logic [4:0]            opcodeFunc,
  input  logic                  Cin,
  input  logic                  Zin,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exLdm,
  output logic                  push,
  output logic                  pop,
  output logic                  memWriteEn,
  output logic                  regWriteEn,
  output logic                  immAndmem,
  output logic                  stm,
  output logic                  ldm,
  output logic                  cWriteEn,
  output logic                  zWriteEn,
  output logic [3:0]            aluOp,
  output logic [1:0]            pcSel,
  output logic                  stall,
  output logic                  flush,
  output logic                  busy,
  output logic [7:0]            spCount,
  output logic                  stackErr
);

  typedef enum logic [1:0] {S_IDLE, S_STARTING, S_RUN, S_FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [7:0] STACK_MAX  = 8'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] sp_q, sp_d;
  logic       err_q, err_d;

  // pc is carried for the datapath's benefit only; decode never looks at it.
  logic unused_pc;
  assign unused_pc = ^pc;

  logic is_alu, is_alu2, is_ldm, is_stm, is_br, is_jmp, is_call, is_ret;
  logic use_rs1, use_rs2, hazard, br_taken, take;

  assign is_alu  = ~opcodeFunc[4];
  assign is_alu2 = (opcodeFunc[4:2] == 3'b110);
  assign is_ldm  = (opcodeFunc == 5'b10000);
  assign is_stm  = (opcodeFunc == 5'b10001);
  assign is_br   = (opcodeFunc[4:2] == 3'b101);
  assign is_jmp  = (opcodeFunc == 5'b11100);
  assign is_call = (opcodeFunc == 5'b11101);
  assign is_ret  = (opcodeFunc == 5'b11110);

  assign use_rs1 = is_alu | is_alu2 | is_ldm | is_stm;
  assign use_rs2 = (opcodeFunc[4:3] == 2'b00) | is_alu2 | is_stm;
  assign hazard  = exLdm & ((use_rs1 & (idRs1 == exRd)) | (use_rs2 & (idRs2 == exRd)));

  always_comb begin
    case (opcodeFunc[1:0])
      2'd0:    br_taken = Zin;
      2'd1:    br_taken = ~Zin;
      2'd2:    br_taken = Cin;
      default: br_taken = ~Cin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    sp_d       = sp_q;
    err_d      = err_q;
    take       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    memWriteEn = 1'b0;
    regWriteEn = 1'b0;
    immAndmem  = 1'b0;
    stm        = 1'b0;
    ldm        = 1'b0;
    cWriteEn   = 1'b0;
    zWriteEn   = 1'b0;
    aluOp      = 4'd0;
    pcSel      = 2'd0;
    stall      = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_STARTING;
      end
      S_STARTING: begin
        if (!start) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (hazard) begin
          stall = 1'b1;
        end else begin
          if (is_alu) begin
            regWriteEn = 1'b1;
            cWriteEn   = 1'b1;
            zWriteEn   = 1'b1;
            immAndmem  = opcodeFunc[3];
            aluOp      = {1'b0, opcodeFunc[2:0]};
          end
          if (is_alu2) begin
            regWriteEn = 1'b1;
            zWriteEn   = 1'b1;
            cWriteEn   = ~opcodeFunc[1];
            aluOp      = {2'b10, opcodeFunc[1:0]};
          end
          if (is_ldm) begin
            regWriteEn = 1'b1;
            immAndmem  = 1'b1;
            ldm        = 1'b1;
          end
          if (is_stm) begin
            memWriteEn = 1'b1;
            immAndmem  = 1'b1;
            stm        = 1'b1;
          end
          if (is_br && br_taken) begin
            pcSel = 2'd3;
            take  = 1'b1;
          end
          if (is_jmp) begin
            pcSel = 2'd1;
            take  = 1'b1;
          end
          // A call/return that would over/underflow the stack degrades to a NOP.
          if (is_call) begin
            if (sp_q < STACK_MAX) begin
              push  = 1'b1;
              pcSel = 2'd1;
              sp_d  = sp_q + 8'd1;
              take  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (is_ret) begin
            if (sp_q != 8'd0) begin
              pop   = 1'b1;
              pcSel = 2'd2;
              sp_d  = sp_q - 8'd1;
              take  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (take) begin
            state_d = S_FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end
      default: begin
        flush = 1'b1;
        if (halt) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else if (fcnt_q == 3'd0) begin
          state_d = S_RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign spCount  = sp_q;
  assign stackErr = err_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a driver applies directed then random stimulus
// and queues model predictions; a negedge monitor compares every DUT output bundle.
module tb_pipe_controller;

  localparam int FD = 2;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, halt = 1'b0;
  logic [11:0] pc = '0;
  logic [4:0] opcodeFunc = '0;
  logic       Cin = 1'b0, Zin = 1'b0;
  logic [2:0] idRs1 = '0, idRs2 = '0, exRd = '0;
  logic       exLdm = 1'b0;
  logic       push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, cWriteEn, zWriteEn;
  logic [3:0] aluOp;
  logic [1:0] pcSel;
  logic       stall, flush, busy;
  logic [7:0] spCount;
  logic       stackErr;

  pipe_controller #(.PC_W(12), .REG_ADDR_W(3), .FLUSH_DEPTH(FD), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc(pc), .opcodeFunc(opcodeFunc),
    .Cin(Cin), .Zin(Zin), .idRs1(idRs1), .idRs2(idRs2), .exRd(exRd), .exLdm(exLdm),
    .push(push), .pop(pop), .memWriteEn(memWriteEn), .regWriteEn(regWriteEn),
    .immAndmem(immAndmem), .stm(stm), .ldm(ldm), .cWriteEn(cWriteEn), .zWriteEn(zWriteEn),
    .aluOp(aluOp), .pcSel(pcSel), .stall(stall), .flush(flush), .busy(busy),
    .spCount(spCount), .stackErr(stackErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       push, pop, mwe, rwe, imm, stm, ldm, cwe, zwe;
    logic [3:0] alu;
    logic [1:0] pcsel;
    logic       stall, flush, busy;
    logic [7:0] sp;
    logic       err;
  } outs_t;

  typedef struct packed {
    outs_t      e;
    logic [4:0] op;
  } item_t;

  item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: phase name plus number of bubble cycles still owed.
  int m_phase = 0;   // 0 idle, 1 starting, 2 run, 3 flushing
  int m_left  = 0;
  int m_sp    = 0;
  bit m_err   = 1'b0;

  task automatic drive(input bit r, input bit s, input bit h, input logic [4:0] op,
                       input bit c, input bit z, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] rd, input bit ld);
    outs_t e;
    int o;
    bit u1, u2, taken;
    item_t it;
    @(posedge clk);
    #1;
    rst = r; start = s; halt = h; opcodeFunc = op; Cin = c; Zin = z;
    idRs1 = r1; idRs2 = r2; exRd = rd; exLdm = ld; pc = 12'($urandom);
    o = int'(op);
    e = '0;
    e.busy = (m_phase != 0);
    e.sp   = 8'(m_sp);
    e.err  = m_err;
    taken  = 1'b0;
    if (m_phase == 2 && !h) begin
      u1 = (o < 18) || (o >= 24 && o < 28);
      u2 = (o < 8) || (o >= 24 && o < 28) || (o == 17);
      if (ld && ((u1 && r1 == rd) || (u2 && r2 == rd))) begin
        e.stall = 1'b1;
      end else if (o < 16) begin
        e.rwe = 1; e.cwe = 1; e.zwe = 1; e.imm = (o >= 8); e.alu = 4'(o % 8);
      end else if (o >= 24 && o < 28) begin
        e.rwe = 1; e.zwe = 1; e.cwe = (o < 26); e.alu = 4'(8 + o % 4);
      end else if (o == 16) begin
        e.rwe = 1; e.imm = 1; e.ldm = 1;
      end else if (o == 17) begin
        e.mwe = 1; e.imm = 1; e.stm = 1;
      end else if (o >= 20 && o <= 23) begin
        taken = (o == 20) ? z : (o == 21) ? !z : (o == 22) ? c : !c;
        if (taken) e.pcsel = 2'd3;
      end else if (o == 28) begin
        taken = 1; e.pcsel = 2'd1;
      end else if (o == 29) begin
        if (m_sp < SD) begin taken = 1; e.push = 1; e.pcsel = 2'd1; end
      end else if (o == 30) begin
        if (m_sp > 0) begin taken = 1; e.pop = 1; e.pcsel = 2'd2; end
      end
    end
    if (m_phase == 3) e.flush = 1'b1;
    if (r) begin
      it.e = e; it.op = op;
      sb_q.push_back(it);
    end
    // advance the model to the next cycle
    if (!r) begin
      m_phase = 0; m_left = 0; m_sp = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (s) m_phase = 1;
        1: if (!s) m_phase = 2;
        2: begin
          if (h) m_phase = 0;
          else begin
            if (!e.stall && o == 29) begin if (m_sp < SD) m_sp++; else m_err = 1; end
            if (!e.stall && o == 30) begin if (m_sp > 0) m_sp--; else m_err = 1; end
            if (taken) begin m_phase = 3; m_left = FD; end
          end
        end
        default: begin
          if (h) m_phase = 0;
          else begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
      endcase
    end
  endtask

  task automatic op1(input logic [4:0] op, input bit c, input bit z);
    drive(1, 0, 0, op, c, z, 3'd0, 3'd0, 3'd7, 0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) op1(5'b10010, 0, 0);
  endtask

  task automatic go_run();
    drive(1, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    item_t it;
    outs_t a;
    if (sb_q.size() != 0) begin
      it = sb_q.pop_front();
      a = '{push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm, cWriteEn, zWriteEn,
            aluOp, pcSel, stall, flush, busy, spCount, stackErr};
      n_checks++;
      n_txn++;
      if (a !== it.e) begin
        n_fail++;
        $display("FAIL outs txn %0d op=%05b actual=%h required=%h", n_txn, it.op, a, it.e);
      end else begin
        $display("txn %0d op=%05b pcSel=%0d stall=%0b flush=%0b sp=%0d err=%0b ok",
                 n_txn, it.op, pcSel, stall, flush, spCount, stackErr);
      end
    end
  end

  initial begin
    // reset, then start held two cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5'b00011, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5'b00011, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 5'b00011, 0, 0, 0, 0, 0, 0);
    op1(5'b00011, 0, 0);
    // load-use hazard then release
    drive(1, 0, 0, 5'b00000, 0, 0, 3'd1, 3'd3, 3'd3, 1);
    drive(1, 0, 0, 5'b00000, 0, 0, 3'd1, 3'd3, 3'd3, 0);
    drive(1, 0, 0, 5'b01000, 0, 0, 3'd1, 3'd3, 3'd3, 1);
    drive(1, 0, 0, 5'b10001, 0, 0, 3'd3, 3'd0, 3'd3, 1);
    drive(1, 0, 0, 5'b11010, 0, 0, 3'd0, 3'd5, 3'd5, 1);
    // branches
    op1(5'b10100, 0, 1); nop(FD + 1);
    op1(5'b10100, 0, 0);
    op1(5'b10111, 0, 0); nop(FD);
    // stack overflow and underflow
    for (int i = 0; i < SD + 1; i++) begin op1(5'b11101, 0, 0); nop(FD); end
    for (int i = 0; i < SD + 1; i++) begin op1(5'b11110, 0, 0); nop(FD); end
    // halt with a taken branch, then halt during flush
    drive(1, 0, 1, 5'b10100, 0, 1, 0, 0, 0, 0);
    nop(1);
    go_run();
    op1(5'b10100, 0, 1);
    drive(1, 0, 1, 5'b10010, 0, 0, 0, 0, 0, 0);
    nop(1);
    go_run();
    // fill stack, force error, reset mid-flush
    for (int i = 0; i < SD; i++) begin op1(5'b11101, 0, 0); nop(FD); end
    op1(5'b11101, 0, 0);
    op1(5'b11100, 0, 0);
    drive(0, 0, 0, 5'b10010, 0, 0, 0, 0, 0, 0);
    nop(2);
    go_run();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), 5'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
